stream_mux_rr: RTL

Parametrised N-to-1 streaming multiplexer with valid/ready handshakes on every input channel and on the output. It is the registered successor of the datapath 2/4/8-to-1 multiplexers. It supports a fixed-select mode (external S, as in the combinational muxes) and a round-robin arbitration mode. It sits between multiple producer stages and a single ALU/result consumer, providing one registered output stage with full backpressure.

---
 rtl/stream_mux_rr.sv | 124 ++++++++++++
 1 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-to-1 streaming multiplexer with valid/ready handshakes and a single
//   registered output stage. Grants one input per cycle, either from the
//   fixed select S (MODE=0) or by round-robin starting at pointer P (MODE=1).
//
// Ports:
//   CLK      rising-edge clock
//   RESET_N  asynchronous active-low reset
//   D        packed channel data, channel i = D[(i+1)*WIDTH-1 : i*WIDTH]
//   V        per-channel valid
//   R        per-channel ready (combinational from V/S/MODE/YR and state)
//   MODE     0 = fixed select by S, 1 = round-robin
//   S        channel select, used only when MODE=0
//   Y        registered output data
//   YV       registered output valid
//   YR       output ready from consumer
//   YS       registered index of the channel that produced Y
module stream_mux_rr #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 8,
    localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [CHANNELS*WIDTH-1:0] D,
    input  logic [CHANNELS-1:0]       V,
    output logic [CHANNELS-1:0]       R,
    input  logic                      MODE,
    input  logic [SEL_W-1:0]          S,
    output logic [WIDTH-1:0]          Y,
    output logic                      YV,
    input  logic                      YR,
    output logic [SEL_W-1:0]          YS
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic             le;
    logic             fx_valid;
    logic             rr_valid;
    logic [SEL_W-1:0] rr_idx;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    // Output register may take a new word when empty or being drained.
    assign le = !YV || YR;

    // Fixed select: compare S against every real channel so an out-of-range
    // S (possible when CHANNELS is not a power of two) never grants.
    always_comb begin
        fx_valid = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (S == SEL_W'(i) && V[i]) begin
                fx_valid = 1'b1;
            end
        end
    end

    // Round-robin search P, P+1, ..., wrapping by subtraction rather than
    // masking so non-power-of-two channel counts wrap correctly.
    always_comb begin
        int unsigned c;
        rr_valid = 1'b0;
        rr_idx   = '0;
        c        = 0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            c = 32'(ptr) + k;
            if (c >= CHANNELS) begin
                c = c - CHANNELS;
            end
            if (!rr_valid && V[c[SEL_W-1:0]]) begin
                rr_valid = 1'b1;
                rr_idx   = c[SEL_W-1:0];
            end
        end
    end

    assign gnt_valid = MODE ? rr_valid : fx_valid;
    assign gnt       = MODE ? rr_idx   : S;
    assign xfer      = gnt_valid && le;

    always_comb begin
        R = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (gnt_valid && gnt == SEL_W'(i)) begin
                R[i] = le;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (gnt == SEL_W'(i)) begin
                gnt_data = D[i*WIDTH +: WIDTH];
            end
        end
    end

    assign ptr_nxt = (32'(gnt) == CHANNELS - 1) ? '0 : gnt + SEL_W'(1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Y   <= '0;
            YV  <= 1'b0;
            YS  <= '0;
            ptr <= '0;
        end else if (le) begin
            if (xfer) begin
                Y  <= gnt_data;
                YS <= gnt;
                YV <= 1'b1;
                if (MODE) begin
                    ptr <= ptr_nxt;
                end
            end else begin
                YV <= 1'b0;
            end
        end
    end

endmodule
